seq_gen_2b: RTL and testbench

Serial 2-bit-per-cycle pattern generator: the transmit side of the {B,A} symbol stream consumed by the team's sequence detectors. It loads a programmable pattern, emits it one 2-bit symbol per clock on `B`/`A` with a `valid` qualifier, and optionally repeats it with idle gaps. It drives detector inputs directly in stimulus/loopback paths and in on-chip self-test.

---
 rtl/seq_gen_pkg.sv | 12 +
 rtl/seq_gen_shreg.sv | 29 ++
 rtl/seq_gen_2b.sv | 155 +++++++++++++++
 tb/tb_seq_gen_2b.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared state encoding and idle symbol for the {B,A} pattern generator
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] SYM_IDLE = 2'b00;

endpackage

// File: rtl/seq_gen_shreg.sv
// rtl/seq_gen_shreg.sv - loadable pattern shift register, shifts left one 2-bit symbol per enable
module seq_gen_shreg
  import seq_gen_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  output logic [1:0]   top
);

  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (clr) begin
      sr <= {(W/2){SYM_IDLE}};
    end else if (load) begin
      sr <= load_val;
    end else if (shift) begin
      sr <= sr << 2;
    end
  end

  assign top = sr[W-1 -: 2];

endmodule

// File: rtl/seq_gen_2b.sv
// rtl/seq_gen_2b.sv - serial 2-bit-per-cycle pattern generator with repeat and idle gaps
// Optional continuous mode is built only when SEQ_GEN_LOOP_EN is defined.
module seq_gen_2b
  import seq_gen_pkg::*;
#(
  parameter int PAT_W   = 16,
  parameter int GAP_CYC = 2,
  parameter int LEN_W   = $clog2(PAT_W/2 + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       reps,
  input  logic             loop,
  output logic             B,
  output logic             A,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int              SYM_W    = (PAT_W > 2) ? $clog2(PAT_W/2) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W/2);
  localparam logic [3:0]      GAP_LAST = 4'(GAP_CYC - 1);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       frm_cnt;
  logic [SYM_W-1:0] sym_cnt;
  logic [3:0]       gap_cnt;

  logic             sr_load;
  logic             sr_shift;
  logic [PAT_W-1:0] sr_val;
  logic [1:0]       sr_top;
  logic             len_ok;
  logic             last_sym;
  logic             loop_hold;
  logic             more;

  assign len_ok   = (len != '0) && (len <= MAX_LEN);
  assign last_sym = (LEN_W'(sym_cnt) + LEN_W'(1)) == len_q;

`ifdef SEQ_GEN_LOOP_EN
  assign loop_hold = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_hold   = 1'b0;
`endif

  assign more = loop_hold || (frm_cnt != 8'd0);

  // Symbol 0 goes straight to the output register, so the shifter is loaded pre-shifted
  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_val   = pat_q << 2;
    case (state)
      IDLE: begin
        sr_load = start && len_ok;
        sr_val  = pat << 2;
      end
      SEND: begin
        if (last_sym) sr_load = more && (GAP_CYC == 0);
        else          sr_shift = 1'b1;
      end
      GAP:     sr_load = (gap_cnt == 4'd0);
      default: sr_load = 1'b0;
    endcase
  end

  seq_gen_shreg #(.W(PAT_W)) u_shreg (
    .clk      (clk),
    .clr      (clr),
    .load     (sr_load),
    .load_val (sr_val),
    .shift    (sr_shift),
    .top      (sr_top)
  );

  always_ff @(posedge clk) begin
    done <= 1'b0;
    err  <= 1'b0;
    if (clr) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      frm_cnt <= '0;
      sym_cnt <= '0;
      gap_cnt <= '0;
      {B, A}  <= SYM_IDLE;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              pat_q   <= pat;
              len_q   <= len;
              frm_cnt <= reps;
              sym_cnt <= '0;
              state   <= SEND;
              {B, A}  <= pat[PAT_W-1 -: 2];
              valid   <= 1'b1;
              busy    <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEND: begin
          if (!last_sym) begin
            sym_cnt <= sym_cnt + SYM_W'(1);
            {B, A}  <= sr_top;
          end else if (more) begin
            // In continuous mode the frame counter is frozen
            if (!loop_hold) frm_cnt <= frm_cnt - 8'd1;
            sym_cnt <= '0;
            if (GAP_CYC == 0) begin
              {B, A} <= pat_q[PAT_W-1 -: 2];
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LAST;
              {B, A}  <= SYM_IDLE;
              valid   <= 1'b0;
            end
          end else begin
            state  <= IDLE;
            done   <= 1'b1;
            {B, A} <= SYM_IDLE;
            valid  <= 1'b0;
            busy   <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state  <= SEND;
            {B, A} <= pat_q[PAT_W-1 -: 2];
            valid  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen_2b.sv
// tb/tb_seq_gen_2b.sv - directed table-driven bench for seq_gen_2b (PAT_W=16, GAP_CYC=2)
module tb_seq_gen_2b;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [15:0] pat;
  logic [3:0]  len;
  logic [7:0]  reps;
  logic        loop_r;
  logic        B, A, valid, busy, done, err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_gen_2b #(.PAT_W(16), .GAP_CYC(2)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .pat   (pat),
    .len   (len),
    .reps  (reps),
    .loop  (loop_r),
    .B     (B),
    .A     (A),
    .valid (valid),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  // expected = {B, A, valid, busy, done, err}
  localparam logic [5:0] O0  = 6'b000000;
  localparam logic [5:0] S00 = 6'b001100;
  localparam logic [5:0] S01 = 6'b011100;
  localparam logic [5:0] S10 = 6'b101100;
  localparam logic [5:0] S11 = 6'b111100;
  localparam logic [5:0] DN  = 6'b000010;
  localparam logic [5:0] ER  = 6'b000001;

  typedef struct {
    string       name;
    logic        clr;
    logic        start;
    logic [3:0]  len;
    logic [15:0] pat;
    logic [7:0]  reps;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic c, logic s, logic [3:0] l,
                              logic [15:0] p, logic [7:0] r, logic [5:0] e);
    vec_t v;
    v.name = n; v.clr = c; v.start = s; v.len = l; v.pat = p; v.reps = r; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(string n, logic [5:0] got, logic [5:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got {B,A,valid,busy,done,err}=%b expected %b", n, got, exp);
    end
  endtask

  logic [1:0] rep_ba [14];
  logic [13:0] rep_v;
  logic [13:0] rep_b;
  logic [13:0] rep_d;

  initial begin
    clr = 1'b1; start = 1'b0; pat = 16'h0; len = 4'd0; reps = 8'd0; loop_r = 1'b0;

    add("reset",        1, 0, 3, 16'hB400, 0, O0);
    add("s_start",      0, 1, 3, 16'hB400, 0, S10);
    add("s_sym1",       0, 0, 3, 16'hB400, 0, S11);
    add("s_sym2",       0, 0, 3, 16'hB400, 0, S01);
    add("s_done",       0, 0, 3, 16'hB400, 0, DN);
    add("s_idle",       0, 0, 3, 16'hB400, 0, O0);
    add("err_len0",     0, 1, 0, 16'hB400, 0, ER);
    add("err_len0_aft", 0, 0, 0, 16'hB400, 0, O0);
    add("err_len9",     0, 1, 9, 16'hB400, 0, ER);
    add("err_len9_aft", 0, 0, 9, 16'hB400, 0, O0);
    add("c_start",      0, 1, 3, 16'hB400, 0, S10);
    add("c_sym1",       0, 0, 3, 16'hB400, 0, S11);
    add("c_clr",        1, 0, 3, 16'hB400, 0, O0);
    add("c_released",   0, 0, 3, 16'hB400, 0, O0);
    add("c_restart",    0, 1, 3, 16'hB400, 0, S10);
    add("c_sym1b",      0, 0, 3, 16'hB400, 0, S11);
    add("c_sym2b",      0, 0, 3, 16'hB400, 0, S01);
    add("c_done",       0, 0, 3, 16'hB400, 0, DN);
    add("b_start",      0, 1, 3, 16'hB400, 0, S10);
    add("b_restart",    0, 1, 1, 16'hFFFF, 5, S11);
    add("b_patchg",     0, 1, 8, 16'h0000, 3, S01);
    add("b_done",       0, 0, 3, 16'h0000, 0, DN);
    add("b_idle",       0, 0, 3, 16'h0000, 0, O0);
    add("l1_start",     0, 1, 1, 16'hC000, 0, S11);
    add("l1_done",      0, 0, 1, 16'hC000, 0, DN);
    add("l8_s0",        0, 1, 8, 16'h1B1B, 0, S00);
    add("l8_s1",        0, 0, 8, 16'h1B1B, 0, S01);
    add("l8_s2",        0, 0, 8, 16'h1B1B, 0, S10);
    add("l8_s3",        0, 0, 8, 16'h1B1B, 0, S11);
    add("l8_s4",        0, 0, 8, 16'h1B1B, 0, S00);
    add("l8_s5",        0, 0, 8, 16'h1B1B, 0, S01);
    add("l8_s6",        0, 0, 8, 16'h1B1B, 0, S10);
    add("l8_s7",        0, 0, 8, 16'h1B1B, 0, S11);
    add("l8_done",      0, 0, 8, 16'h1B1B, 0, DN);
    add("l8_idle",      0, 0, 8, 16'h1B1B, 0, O0);

    for (int i = 0; i < vecs.size(); i++) begin
      clr = vecs[i].clr; start = vecs[i].start; len = vecs[i].len;
      pat = vecs[i].pat; reps = vecs[i].reps;
      @(posedge clk); #1;
      check(vecs[i].name, {B, A, valid, busy, done, err}, vecs[i].exp);
    end

    // reps=2: three frames of 10,11,01 separated by two-cycle gaps
    rep_ba = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00,
               2'b10, 2'b11, 2'b01, 2'b00};
    rep_v  = 14'b11100111001110;
    rep_b  = 14'b11111111111110;
    rep_d  = 14'b00000000000001;
    clr = 1'b0; pat = 16'hB400; len = 4'd3; reps = 8'd2;
    for (int i = 0; i < 14; i++) begin
      start = (i == 0);
      @(posedge clk); #1;
      check($sformatf("reps_cyc%0d", i), {B, A, valid, busy, done, err},
            {rep_ba[i], rep_v[13-i], rep_b[13-i], rep_d[13-i], 1'b0});
    end
    start = 1'b0; reps = 8'd0;
    @(posedge clk); #1;
    check("reps_idle", {B, A, valid, busy, done, err}, O0);

`ifdef SEQ_GEN_LOOP_EN
    begin
      int frames = 0;
      int dones  = 0;
      logic prev_v = 1'b0;
      bit finished = 1'b0;
      loop_r = 1'b1; start = 1'b1; len = 4'd3; pat = 16'hB400; reps = 8'd0;
      for (int c = 0; c < 80 && !finished; c++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (c == 19) loop_r = 1'b0;
        if (valid && !prev_v) frames++;
        prev_v = valid;
        if (done) begin
          dones++;
          if (dones == 1) begin
            repeat (8) begin
              @(posedge clk); #1;
              if (done) dones++;
              if (valid) frames++;
            end
            finished = 1'b1;
          end
        end
      end
      tests++;
      if (!finished) begin
        fails++;
        $display("FAIL loop_timeout: got no done within bound, expected done");
      end
      tests++;
      if (frames != 5) begin
        fails++;
        $display("FAIL loop_frames: got %0d frames expected 5", frames);
      end
      tests++;
      if (dones != 1) begin
        fails++;
        $display("FAIL loop_dones: got %0d done pulses expected 1", dones);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
